// File: rtl/gshare_bp.sv
// gshare branch predictor: PHT of 2-bit counters indexed by PC ^ GHR,
// plus a direct-mapped BTB; speculative GHR with mispredict recovery.
module gshare_bp #(
    parameter int BTB_IDX_W = 5,
    parameter int HIST_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              fetch_valid,
    output logic [31:0]       predict_pc,
    output logic              istaken,
    output logic [HIST_W-1:0] pred_ghr,
    input  logic              upd_valid,
    input  logic              upd_is_branch,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic [HIST_W-1:0] upd_ghr,
    input  logic              upd_mispredict,
    output logic [31:0]       lookups,
    output logic [31:0]       mispredicts
);

    localparam int BTB_N = 1 << BTB_IDX_W;
    localparam int TAG_W = 30 - BTB_IDX_W;
    localparam int PHT_N = 1 << HIST_W;

    logic              r_btb_valid [BTB_N];
    logic [TAG_W-1:0]  r_btb_tag   [BTB_N];
    logic              r_btb_br    [BTB_N];
    logic [31:0]       r_btb_tgt   [BTB_N];
    logic [1:0]        r_pht       [PHT_N];
    logic [HIST_W-1:0] r_ghr;
    logic [31:0]       r_lookups;
    logic [31:0]       r_mispredicts;

    logic [BTB_IDX_W-1:0] w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_hit;
    logic [HIST_W-1:0]    w_pht_idx;
    logic                 w_istaken;

    logic [BTB_IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0]     w_utag;
    logic                 w_uhit;
    logic [HIST_W-1:0]    w_upht_idx;
    logic [1:0]           w_ucnt;
    logic [1:0]           w_ucnt_next;
    logic [31:0]          w_utgt_next;
    logic [HIST_W-1:0]    w_ghr_next;
    logic                 w_unused;

    assign w_unused = ^{pc[1:0], upd_pc[1:0]};

    assign w_idx     = pc[BTB_IDX_W+1:2];
    assign w_tag     = pc[31:BTB_IDX_W+2];
    assign w_hit     = r_btb_valid[w_idx] && (r_btb_tag[w_idx] == w_tag);
    assign w_pht_idx = pc[HIST_W+1:2] ^ r_ghr;
    assign w_istaken = w_hit && (!r_btb_br[w_idx] || r_pht[w_pht_idx][1]);

    assign istaken    = w_istaken;
    assign predict_pc = w_istaken ? r_btb_tgt[w_idx] : pc + 32'd4;
    assign pred_ghr   = r_ghr;

    assign w_uidx     = upd_pc[BTB_IDX_W+1:2];
    assign w_utag     = upd_pc[31:BTB_IDX_W+2];
    assign w_uhit     = r_btb_valid[w_uidx] && (r_btb_tag[w_uidx] == w_utag);
    assign w_upht_idx = upd_pc[HIST_W+1:2] ^ upd_ghr;
    assign w_ucnt     = r_pht[w_upht_idx];

    // A not-taken branch allocating a fresh entry gets the fall-through PC.
    always_comb begin
        w_utgt_next = upd_pc + 32'd4;
        if (upd_taken)
            w_utgt_next = upd_target;
        else if (w_uhit)
            w_utgt_next = r_btb_tgt[w_uidx];
    end

    always_comb begin
        w_ucnt_next = w_ucnt;
        if (upd_taken) begin
            if (w_ucnt != 2'b11)
                w_ucnt_next = w_ucnt + 2'd1;
        end else begin
            if (w_ucnt != 2'b00)
                w_ucnt_next = w_ucnt - 2'd1;
        end
    end

    // Recovery from EX takes priority over the fetch-time shift.
    always_comb begin
        w_ghr_next = r_ghr;
        if (upd_valid && upd_mispredict) begin
            if (upd_is_branch)
                w_ghr_next = {upd_ghr[HIST_W-2:0], upd_taken};
            else
                w_ghr_next = upd_ghr;
        end else if (fetch_valid && w_hit && r_btb_br[w_idx]) begin
            w_ghr_next = {r_ghr[HIST_W-2:0], w_istaken};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_N; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_btb_tag[i]   <= '0;
                r_btb_br[i]    <= 1'b0;
                r_btb_tgt[i]   <= '0;
            end
        end else if (upd_valid) begin
            r_btb_valid[w_uidx] <= 1'b1;
            r_btb_tag[w_uidx]   <= w_utag;
            r_btb_br[w_uidx]    <= upd_is_branch;
            r_btb_tgt[w_uidx]   <= w_utgt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHT_N; i++)
                r_pht[i] <= 2'b01;
        end else if (upd_valid && upd_is_branch) begin
            r_pht[w_upht_idx] <= w_ucnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ghr         <= '0;
            r_lookups     <= '0;
            r_mispredicts <= '0;
        end else begin
            r_ghr <= w_ghr_next;
            if (upd_valid) begin
                r_lookups <= r_lookups + 32'd1;
                if (upd_mispredict)
                    r_mispredicts <= r_mispredicts + 32'd1;
            end
        end
    end

    assign lookups     = r_lookups;
    assign mispredicts = r_mispredicts;

endmodule
